snitch_icache_lookup_arb: RTL and testbench

//  Shares one serial L1 lookup pipeline (tag stage + data stage) between NR_PORTS fetch requesters.
//  - Round-robin arbitration of lookup requests; port index tagged into the upper ID bits.
//  - Bounded in-flight count; responses routed back to the originating port.
//  - Flush sequencing: stop intake, drain the pipeline, then hand one flush to the lookup.
//  - Sits between the per-core fetch front-ends and the lookup.

---
 rtl/snitch_icache_lookup_arb_pkg.sv | 17 +
 rtl/snitch_icache_lookup_arb_rr.sv | 66 ++++++
 rtl/snitch_icache_lookup_arb.sv | 184 ++++++++++++++++++
 tb/tb_snitch_icache_lookup_arb.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snitch_icache_lookup_arb_pkg.sv
// Shared definitions for the lookup arbiter: flush FSM state encoding and
// a helper for the width of a port index.
package snitch_icache_lookup_arb_pkg;

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t ArbIdle  = 2'd0;
    localparam arb_state_t ArbDrain = 2'd1;
    localparam arb_state_t ArbFlush = 2'd2;
    localparam arb_state_t ArbDone  = 2'd3;

    // A single port still needs one bit so that the {port, id} tag is well formed.
    function automatic int unsigned port_width(input int unsigned nr_ports);
        return (nr_ports > 1) ? $clog2(nr_ports) : 1;
    endfunction

endpackage

// File: rtl/snitch_icache_lookup_arb_rr.sv
// Round-robin arbiter with a lock-in grant.
// Picks the first requesting port at or after the pointer. Once valid_o is
// raised the grant is frozen until ready_i, even if enable_i drops meanwhile.
// Ports:
//   clk_i, rst_ni  clock, async active-low reset
//   req_i          per-port request
//   enable_i       allow a new (unlocked) grant
//   ready_i        downstream ready
//   valid_o        grant valid
//   idx_o          granted port index
module snitch_icache_lookup_arb_rr #(
    parameter int unsigned NrPorts = 2,
    parameter int unsigned IdxW    = 1
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [NrPorts-1:0] req_i,
    input  logic               enable_i,
    input  logic               ready_i,
    output logic               valid_o,
    output logic [IdxW-1:0]    idx_o
);

    logic [IdxW-1:0] ptr_q, ptr_d;
    logic [IdxW-1:0] lock_idx_q, lock_idx_d;
    logic            lock_q, lock_d;
    logic [IdxW-1:0] pick, cand;
    logic            found;

    always_comb begin
        pick  = ptr_q;
        cand  = ptr_q;
        found = 1'b0;
        for (int unsigned i = 0; i < NrPorts; i++) begin
            cand = IdxW'((32'(ptr_q) + i) % NrPorts);
            if (!found && req_i[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        valid_o    = lock_q | (enable_i & found);
        idx_o      = lock_q ? lock_idx_q : pick;
        lock_d     = valid_o & ~ready_i;
        lock_idx_d = idx_o;
        ptr_d      = ptr_q;
        if (valid_o && ready_i) begin
            ptr_d = (idx_o == IdxW'(NrPorts - 1)) ? '0 : idx_o + IdxW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q      <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
        end else begin
            ptr_q      <= ptr_d;
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
        end
    end

endmodule

// File: rtl/snitch_icache_lookup_arb.sv
// Shares one serial L1 lookup pipeline between NR_PORTS fetch requesters.
// Requests are arbitrated round-robin and tagged with the port index in the
// upper lookup-ID bits; responses are steered back by that tag. A flush stops
// intake, waits for the pipeline to empty, then hands one flush to the lookup.
// Ports:
//   flush_valid_i / flush_ready_o       system flush request / completion pulse
//   req_*_i, req_ready_o                per-port fetch requests (flattened)
//   rsp_*_o (broadcast), rsp_valid_o    responses, valid one-hot per port
//   lk_flush_valid_o / lk_flush_ready_i flush towards the lookup
//   lk_addr_o, lk_id_o, lk_valid_o      request towards the lookup
//   lk_*_i, lk_valid_i, lk_ready_o      response from the lookup
module snitch_icache_lookup_arb import snitch_icache_lookup_arb_pkg::*; #(
    parameter int unsigned NR_PORTS     = 2,
    parameter int unsigned FETCH_AW     = 32,
    parameter int unsigned ID_WIDTH     = 2,
    parameter int unsigned LINE_WIDTH   = 128,
    parameter int unsigned SET_ALIGN    = 1,
    parameter int unsigned MAX_INFLIGHT = 2,
    localparam int unsigned PortW       = port_width(NR_PORTS),
    localparam int unsigned LkIdW       = ID_WIDTH + PortW
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         flush_valid_i,
    output logic                         flush_ready_o,
    input  logic [NR_PORTS*FETCH_AW-1:0] req_addr_i,
    input  logic [NR_PORTS*ID_WIDTH-1:0] req_id_i,
    input  logic [NR_PORTS-1:0]          req_valid_i,
    output logic [NR_PORTS-1:0]          req_ready_o,
    output logic [FETCH_AW-1:0]          rsp_addr_o,
    output logic [ID_WIDTH-1:0]          rsp_id_o,
    output logic [SET_ALIGN-1:0]         rsp_set_o,
    output logic                         rsp_hit_o,
    output logic [LINE_WIDTH-1:0]        rsp_data_o,
    output logic                         rsp_error_o,
    output logic [NR_PORTS-1:0]          rsp_valid_o,
    input  logic [NR_PORTS-1:0]          rsp_ready_i,
    output logic                         lk_flush_valid_o,
    input  logic                         lk_flush_ready_i,
    output logic [FETCH_AW-1:0]          lk_addr_o,
    output logic [LkIdW-1:0]             lk_id_o,
    output logic                         lk_valid_o,
    input  logic                         lk_ready_i,
    input  logic [FETCH_AW-1:0]          lk_addr_i,
    input  logic [LkIdW-1:0]             lk_id_i,
    input  logic [SET_ALIGN-1:0]         lk_set_i,
    input  logic                         lk_hit_i,
    input  logic [LINE_WIDTH-1:0]        lk_data_i,
    input  logic                         lk_error_i,
    input  logic                         lk_valid_i,
    output logic                         lk_ready_o
);

    localparam int unsigned CntW = $clog2(MAX_INFLIGHT + 1);

    typedef struct packed {
        logic [FETCH_AW-1:0] addr;
        logic [ID_WIDTH-1:0] id;
    } lookup_arb_req_t;

    lookup_arb_req_t req_pl [NR_PORTS];
    lookup_arb_req_t grant_pl;
    logic [PortW-1:0] grant_idx;
    logic             can_issue;
    logic             lock_next;
    logic             lk_hs, rsp_hs;

    arb_state_t       state_q, state_d;
    logic [CntW-1:0]  inflight_q, inflight_d;

    logic [PortW-1:0] rsp_port;
    logic             rsp_port_ok;

    // ---------------------------------------------------------------------
    // Request path
    // ---------------------------------------------------------------------
    always_comb begin
        for (int unsigned i = 0; i < NR_PORTS; i++) begin
            req_pl[i].addr = req_addr_i[i*FETCH_AW +: FETCH_AW];
            req_pl[i].id   = req_id_i[i*ID_WIDTH +: ID_WIDTH];
        end
    end

    assign can_issue = (state_q == ArbIdle) && (inflight_q < CntW'(MAX_INFLIGHT));

    snitch_icache_lookup_arb_rr #(
        .NrPorts ( NR_PORTS ),
        .IdxW    ( PortW    )
    ) i_rr (
        .clk_i    ( clk_i       ),
        .rst_ni   ( rst_ni      ),
        .req_i    ( req_valid_i ),
        .enable_i ( can_issue   ),
        .ready_i  ( lk_ready_i  ),
        .valid_o  ( lk_valid_o  ),
        .idx_o    ( grant_idx   )
    );

    assign grant_pl  = req_pl[grant_idx];
    assign lk_addr_o = grant_pl.addr;
    assign lk_id_o   = {grant_idx, grant_pl.id};
    assign lock_next = lk_valid_o & ~lk_ready_i;
    assign lk_hs     = lk_valid_o & lk_ready_i;

    always_comb begin
        req_ready_o = '0;
        if (lk_valid_o) req_ready_o[grant_idx] = lk_ready_i;
    end

    // ---------------------------------------------------------------------
    // Response path: combinational demux on the port tag
    // ---------------------------------------------------------------------
    assign rsp_port    = lk_id_i[LkIdW-1 -: PortW];
    assign rsp_addr_o  = lk_addr_i;
    assign rsp_id_o    = lk_id_i[ID_WIDTH-1:0];
    assign rsp_set_o   = lk_set_i;
    assign rsp_hit_o   = lk_hit_i;
    assign rsp_data_o  = lk_data_i;
    assign rsp_error_o = lk_error_i;

    always_comb begin
        rsp_valid_o = '0;
        rsp_port_ok = 1'b0;
        // An unknown tag is swallowed so the lookup never stalls on it.
        lk_ready_o  = 1'b1;
        for (int unsigned i = 0; i < NR_PORTS; i++) begin
            if (rsp_port == PortW'(i)) begin
                rsp_valid_o[i] = lk_valid_i;
                lk_ready_o     = rsp_ready_i[i];
                rsp_port_ok    = 1'b1;
            end
        end
    end

    assign rsp_hs = lk_valid_i & lk_ready_o;

    // ---------------------------------------------------------------------
    // In-flight counter
    // ---------------------------------------------------------------------
    always_comb begin
        inflight_d = inflight_q;
        if (lk_hs && !rsp_hs) begin
            inflight_d = inflight_q + CntW'(1);
        end else if (!lk_hs && rsp_hs && inflight_q != '0) begin
            inflight_d = inflight_q - CntW'(1);
        end
    end

    // ---------------------------------------------------------------------
    // Flush sequencing
    // ---------------------------------------------------------------------
    // DRAIN looks at next-state count/lock so the flush is issued the cycle
    // right after the last response retires.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ArbIdle:  if (flush_valid_i) state_d = ArbDrain;
            ArbDrain: if (inflight_d == '0 && !lock_next) state_d = ArbFlush;
            ArbFlush: if (lk_flush_ready_i) state_d = ArbDone;
            ArbDone:  state_d = ArbIdle;
            default:  state_d = ArbIdle;
        endcase
    end

    assign lk_flush_valid_o = (state_q == ArbFlush);
    assign flush_ready_o    = (state_q == ArbDone);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ArbIdle;
            inflight_q <= '0;
        end else begin
            state_q    <= state_d;
            inflight_q <= inflight_d;
        end
    end

    rsp_port_known: assert property (@(posedge clk_i) disable iff (!rst_ni)
        lk_valid_i |-> rsp_port_ok);

    no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        rsp_hs |-> (inflight_q != '0));

endmodule

// File: tb/tb_snitch_icache_lookup_arb.sv
module tb_snitch_icache_lookup_arb;

    localparam int N    = 2;
    localparam int AW   = 32;
    localparam int IW   = 2;
    localparam int LW   = 128;
    localparam int SW   = 1;
    localparam int MAXI = 2;
    localparam int PW   = 1;
    localparam int LKW  = IW + PW;

    logic            clk = 1'b0;
    logic            rst_ni;
    logic            flush_valid_i, flush_ready_o;
    logic [N*AW-1:0] req_addr_i;
    logic [N*IW-1:0] req_id_i;
    logic [N-1:0]    req_valid_i, req_ready_o;
    logic [AW-1:0]   rsp_addr_o;
    logic [IW-1:0]   rsp_id_o;
    logic [SW-1:0]   rsp_set_o;
    logic            rsp_hit_o, rsp_error_o;
    logic [LW-1:0]   rsp_data_o;
    logic [N-1:0]    rsp_valid_o, rsp_ready_i;
    logic            lk_flush_valid_o, lk_flush_ready_i;
    logic [AW-1:0]   lk_addr_o, lk_addr_i;
    logic [LKW-1:0]  lk_id_o, lk_id_i;
    logic            lk_valid_o, lk_ready_i;
    logic [SW-1:0]   lk_set_i;
    logic            lk_hit_i, lk_error_i, lk_valid_i, lk_ready_o;
    logic [LW-1:0]   lk_data_i;

    snitch_icache_lookup_arb #(
        .NR_PORTS(N), .FETCH_AW(AW), .ID_WIDTH(IW), .LINE_WIDTH(LW),
        .SET_ALIGN(SW), .MAX_INFLIGHT(MAXI)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .flush_valid_i(flush_valid_i), .flush_ready_o(flush_ready_o),
        .req_addr_i(req_addr_i), .req_id_i(req_id_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .rsp_addr_o(rsp_addr_o), .rsp_id_o(rsp_id_o), .rsp_set_o(rsp_set_o),
        .rsp_hit_o(rsp_hit_o), .rsp_data_o(rsp_data_o), .rsp_error_o(rsp_error_o),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .lk_flush_valid_o(lk_flush_valid_o), .lk_flush_ready_i(lk_flush_ready_i),
        .lk_addr_o(lk_addr_o), .lk_id_o(lk_id_o), .lk_valid_o(lk_valid_o),
        .lk_ready_i(lk_ready_i),
        .lk_addr_i(lk_addr_i), .lk_id_i(lk_id_i), .lk_set_i(lk_set_i),
        .lk_hit_i(lk_hit_i), .lk_data_i(lk_data_i), .lk_error_i(lk_error_i),
        .lk_valid_i(lk_valid_i), .lk_ready_o(lk_ready_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Stimulus knobs (percent probabilities)
    int req_pct [N];
    int rsprdy_pct [N];
    int lkrdy_pct, rsp_pct, flkrdy_pct;
    int fix_id = -1;
    bit fl_req;

    // Requester state: a port keeps valid/payload until handshaken
    bit            pend [N];
    logic [AW-1:0] paddr [N];
    logic [IW-1:0] pid [N];

    // Lookup model: accepted requests in order, head presented as response
    typedef struct { logic [AW-1:0] addr; logic [LKW-1:0] id; } lk_t;
    lk_t lkq [$];
    bit  pres;

    // Reference model
    int m_ptr, m_infl, m_phase, m_lockp;  // phase: 0 idle, 1 drain, 2 flush, 3 done
    bit m_locked;
    bit e_lkv, e_lkrdy;
    int e_g;

    function automatic logic [LW-1:0] line_of(input logic [AW-1:0] a);
        return {a ^ 32'hDEADBEEF, ~a, a, a + 32'd1};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr = 0; m_infl = 0; m_phase = 0; m_locked = 0; m_lockp = 0;
        fl_req = 0; pres = 0; lkq.delete();
        for (int p = 0; p < N; p++) pend[p] = 0;
    endtask

    task automatic zero_inputs();
        flush_valid_i = 0; req_addr_i = '0; req_id_i = '0; req_valid_i = '0;
        rsp_ready_i = '0; lk_flush_ready_i = 0; lk_ready_i = 0;
        lk_addr_i = '0; lk_id_i = '0; lk_set_i = '0; lk_hit_i = 0;
        lk_data_i = '0; lk_error_i = 0; lk_valid_i = 0;
    endtask

    task automatic drive();
        for (int p = 0; p < N; p++) begin
            if (!pend[p] && $urandom_range(99) < req_pct[p]) begin
                pend[p]  = 1;
                paddr[p] = $urandom & 32'hFFFF_FFFC;
                pid[p]   = (fix_id >= 0) ? IW'(fix_id) : IW'($urandom);
            end
            req_valid_i[p]           = pend[p];
            req_addr_i[p*AW +: AW]   = pend[p] ? paddr[p] : '0;
            req_id_i[p*IW +: IW]     = pend[p] ? pid[p] : '0;
            rsp_ready_i[p]           = ($urandom_range(99) < rsprdy_pct[p]);
        end
        lk_ready_i       = ($urandom_range(99) < lkrdy_pct);
        lk_flush_ready_i = ($urandom_range(99) < flkrdy_pct);
        flush_valid_i    = fl_req;
        if (!pres && lkq.size() > 0 && $urandom_range(99) < rsp_pct) pres = 1;
        lk_valid_i = pres;
        if (pres) begin
            lk_addr_i  = lkq[0].addr;
            lk_id_i    = lkq[0].id;
            lk_set_i   = lkq[0].addr[4];
            lk_hit_i   = lkq[0].addr[5];
            lk_error_i = lkq[0].addr[6];
            lk_data_i  = line_of(lkq[0].addr);
        end else begin
            lk_addr_i = '0; lk_id_i = '0; lk_set_i = '0;
            lk_hit_i = 0; lk_error_i = 0; lk_data_i = '0;
        end
    endtask

    // Compare all outputs against the model (mid-cycle, inputs stable)
    task automatic check();
        logic [LKW-1:0] eid;
        logic [N-1:0]   ev;
        int             p;
        bit             found = 0;
        e_g = m_ptr;
        if (m_locked) e_g = m_lockp;
        else for (int i = 0; i < N; i++)
            if (!found && req_valid_i[(m_ptr + i) % N]) begin
                e_g = (m_ptr + i) % N; found = 1;
            end
        e_lkv = m_locked || ((req_valid_i != '0) && m_phase == 0 && m_infl < MAXI);
        chk("lk_valid", lk_valid_o, e_lkv);
        if (e_lkv) begin
            eid = {PW'(e_g), pid[e_g]};
            chk("lk_id", lk_id_o, eid);
            chk("lk_addr", lk_addr_o, paddr[e_g]);
        end
        ev = '0;
        if (e_lkv && lk_ready_i) ev[e_g] = 1'b1;
        chk("req_ready", req_ready_o, ev);
        ev = '0;
        e_lkrdy = 0;
        if (pres) begin
            p = int'(lkq[0].id[LKW-1 -: PW]);
            ev[p] = 1'b1;
            e_lkrdy = rsp_ready_i[p];
            chk("lk_ready_o", lk_ready_o, e_lkrdy);
            chk("rsp_id", rsp_id_o, lkq[0].id[IW-1:0]);
            chk("rsp_addr", rsp_addr_o, lkq[0].addr);
            chk("rsp_data", rsp_data_o, line_of(lkq[0].addr));
            chk("rsp_attr", {rsp_set_o, rsp_hit_o, rsp_error_o},
                {lkq[0].addr[4], lkq[0].addr[5], lkq[0].addr[6]});
        end
        chk("rsp_valid", rsp_valid_o, ev);
        chk("lk_flush_valid", lk_flush_valid_o, m_phase == 2);
        chk("flush_ready", flush_ready_o, m_phase == 3);
        chk("inflight", dut.inflight_q, m_infl);
    endtask

    // Advance the model across one rising edge
    task automatic update();
        bit lkhs, rsphs;
        lkhs  = e_lkv && lk_ready_i;
        rsphs = pres && e_lkrdy;
        if (rsphs) begin
            void'(lkq.pop_front());
            pres = 0;
        end
        if (lkhs) begin
            lkq.push_back('{paddr[e_g], {PW'(e_g), pid[e_g]}});
            pend[e_g] = 0;
            m_ptr     = (e_g + 1) % N;
            m_locked  = 0;
        end else if (e_lkv) begin
            m_locked = 1;
            m_lockp  = e_g;
        end
        m_infl = m_infl + int'(lkhs) - int'(rsphs);
        case (m_phase)
            0: if (flush_valid_i) m_phase = 1;
            1: if (m_infl == 0 && !m_locked) m_phase = 2;
            2: if (lk_flush_ready_i) m_phase = 3;
            default: begin m_phase = 0; fl_req = 0; end
        endcase
    endtask

    task automatic half1();
        drive();
        @(negedge clk);
        check();
    endtask

    task automatic half2();
        @(posedge clk);
        update();
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) begin half1(); half2(); end
    endtask

    task automatic set_all(input int rq, input int lkr, input int rs, input int rsr, input int flr);
        for (int p = 0; p < N; p++) begin req_pct[p] = rq; rsprdy_pct[p] = rsr; end
        lkrdy_pct = lkr; rsp_pct = rs; flkrdy_pct = flr;
    endtask

    // Stop new requests and let everything outstanding retire (bounded)
    task automatic drain();
        bit done = 0;
        set_all(0, 100, 100, 100, 100);
        for (int c = 0; c < 60 && !done; c++) begin
            run(1);
            done = (lkq.size() == 0) && !pend[0] && !pend[1] && (m_infl == 0)
                   && (m_phase == 0) && !fl_req;
        end
        chk("drain_done", done, 1'b1);
    endtask

    task automatic do_reset();
        #2;
        rst_ni = 0;
        zero_inputs();
        model_reset();
        #1;
        chk("rst_lk_valid", lk_valid_o, 0);
        chk("rst_req_ready", req_ready_o, 0);
        chk("rst_rsp_valid", rsp_valid_o, 0);
        chk("rst_lk_flush", lk_flush_valid_o, 0);
        chk("rst_flush_ready", flush_ready_o, 0);
        chk("rst_lk_ready", lk_ready_o, 0);
        chk("rst_lk_id", lk_id_o, 0);
        chk("rst_state", dut.state_q, 0);
        chk("rst_inflight", dut.inflight_q, 0);
        @(negedge clk);
        rst_ni = 1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [AW-1:0] a0;
        int            pulses;
        rst_ni = 0;
        zero_inputs();
        model_reset();
        set_all(0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        do_reset();

        // 1: both ports busy, full throughput -> alternating grants
        set_all(100, 100, 100, 100, 100);
        run(12);
        drain();

        // 2: no responses -> stops at MAX_INFLIGHT, resumes after one response
        set_all(100, 100, 0, 100, 100);
        run(4);
        half1(); chk("t2_full", lk_valid_o, 0); half2();
        rsp_pct = 100;
        run(6);
        drain();

        // 3: port 1 locked while lk_ready_i low, port 0 arrives later
        set_all(0, 0, 100, 100, 100);
        req_pct[1] = 100;
        half1(); chk("t3_grant", lk_id_o[LKW-1], 1); a0 = lk_addr_o; half2();
        req_pct[0] = 100;
        repeat (5) begin
            half1();
            chk("t3_grant", lk_id_o[LKW-1], 1);
            chk("t3_addr", lk_addr_o, a0);
            half2();
        end
        lkrdy_pct = 100;
        half1(); chk("t3_first", req_ready_o, 2'b10); half2();
        run(4);
        drain();

        // 4: response to port 1, id 3, port 1 not ready
        fix_id = 3;
        set_all(0, 100, 0, 100, 100);
        req_pct[1] = 100;
        run(1);
        req_pct[1] = 0;
        rsp_pct = 100;
        rsprdy_pct[1] = 0;
        repeat (3) begin
            half1();
            chk("t4_valid", rsp_valid_o, 2'b10);
            chk("t4_id", rsp_id_o, 3);
            chk("t4_ready", lk_ready_o, 0);
            half2();
        end
        rsprdy_pct[1] = 100;
        half1(); chk("t4_release", lk_ready_o, 1); half2();
        fix_id = -1;
        drain();

        // 5: flush with two in flight
        set_all(100, 100, 0, 100, 100);
        run(3);
        fl_req = 1;
        req_pct[0] = 0; req_pct[1] = 0;
        run(4);
        rsp_pct = 100;
        pulses = 0;
        repeat (10) begin
            half1(); if (flush_ready_o) pulses++; half2();
        end
        chk("t5_pulses", pulses, 1);
        drain();

        // minimum flush latency on an empty pipeline
        fl_req = 1;
        for (int i = 0; i < 4; i++) begin
            half1(); chk("min_latency", flush_ready_o, i == 3); half2();
        end
        drain();

        // randomized traffic with occasional flushes
        for (int blk = 0; blk < 15; blk++) begin
            for (int p = 0; p < N; p++) begin
                req_pct[p] = $urandom_range(100);
                rsprdy_pct[p] = $urandom_range(100, 20);
            end
            lkrdy_pct = $urandom_range(100, 20);
            rsp_pct = $urandom_range(100, 20);
            flkrdy_pct = $urandom_range(100, 20);
            if (m_phase == 0 && !fl_req && $urandom_range(2) == 0) fl_req = 1;
            run(20);
        end
        drain();

        // 6: simultaneous request/response handshakes keep the count steady
        set_all(100, 100, 100, 100, 100);
        run(2);
        repeat (20) begin
            half1(); chk("t6_inflight", dut.inflight_q, 1); half2();
        end
        fl_req = 1;
        rsp_pct = 0;
        run(3);
        half1(); chk("t6_drain", dut.state_q, 1); half2();
        do_reset();
        set_all(100, 100, 100, 100, 100);
        run(10);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
